// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the MEM-stage data-memory responder: access size
// encodings, the responder FSM state type, and helpers that turn a request's
// size/byte-offset into RAM write strobes, replicated store data and
// lane-extracted, extended load data.
// ---------------------------------------------------------------------------
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // The reserved size code behaves exactly like a word access.
   function automatic logic [1:0] norm_size(input logic [1:0] size);
      return (size == 2'b11) ? SZ_WORD : size;
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SZ_HALF: return off[0];
         SZ_WORD: return (off != 2'b00);
         default: return 1'b0;
      endcase
   endfunction

   // Drops the offset bits a naturally aligned access of this size cannot use.
   function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SZ_HALF: return {off[1], 1'b0};
         SZ_WORD: return 2'b00;
         default: return off;
      endcase
   endfunction

   function automatic logic [3:0] gen_strobe(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SZ_BYTE: return 4'b0001 << off;
         SZ_HALF: return 4'b0011 << off;
         default: return 4'b1111;
      endcase
   endfunction

   // Store data arrives right-aligned; copying it into every lane lets the
   // strobe alone pick which bytes land in the RAM.
   function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] wdata);
      case (size)
         SZ_BYTE: return {4{wdata[7:0]}};
         SZ_HALF: return {2{wdata[15:0]}};
         default: return wdata;
      endcase
   endfunction

   function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic sgn);
      logic [31:0] sh;
      sh = word >> {off, 3'b000};
      case (size)
         SZ_BYTE: return sgn ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
         SZ_HALF: return sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
         default: return word;
      endcase
   endfunction

endpackage

// File: rtl/dmem_bank.sv
// ---------------------------------------------------------------------------
// dmem_bank
// Single-port 2^ADDR_W x 32 synchronous RAM with per-byte write enables and
// a registered read. Contents are not reset.
//   clk    clock
//   en     port enable; read data register updates only when set
//   we     byte write enables (bit i writes byte lane i)
//   addr   word index
//   wdata  write data (lane-replicated by the caller)
//   rdata  registered read data (old contents on a simultaneous write)
// ---------------------------------------------------------------------------
module dmem_bank #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              en,
   input  logic [3:0]        we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem [0:(1<<ADDR_W)-1];

   // One access per enabled cycle: strobed byte writes plus a read-first
   // capture of the addressed word. Holding rdata while en is low keeps a
   // completed load's data steady for as long as the response waits.
   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
               mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Slave end of the MEM-stage memory interface. Accepts one load/store over a
// valid/ready request channel, waits LATENCY cycles, performs the RAM access
// and holds the response on a valid/ready response channel until consumed.
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake
//   req_we, req_size, req_signed    store flag, 00 byte/01 half/10,11 word, sign-extend
//   req_addr, req_wdata             byte address, right-aligned store data
//   resp_valid/resp_ready           response handshake
//   resp_rdata, resp_err            extended load data, misaligned flag
// Build option: DMEM_MISALIGN_CHECK_EN makes misaligned accesses skip the RAM
// and answer with resp_err=1; without it the offset is forced aligned.
// ---------------------------------------------------------------------------
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   state_t            state, state_n;
   logic [3:0]        cnt;
   logic              lat_we, lat_signed, lat_err;
   logic [1:0]        lat_size, lat_off;
   logic [ADDR_W-1:0] lat_idx;
   logic [31:0]       lat_wdata;

   logic [1:0]        req_sz, req_off;
   logic              req_err;
   logic              acc_we, acc_err, acc_fire;
   logic [1:0]        acc_size, acc_off;
   logic [ADDR_W-1:0] acc_idx;
   logic [31:0]       acc_wdata, bank_rdata;
   logic [3:0]        bank_we;

   // Upper address bits alias onto the RAM and are deliberately unused.
   logic unused_addr_bits;
   assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

   // Decode the live request: normalise size, decide whether it is an error,
   // and work out the lane offset the access will actually use.
   always_comb begin
      req_sz  = norm_size(req_size);
      req_off = align_off(req_sz, req_addr[1:0]);
`ifdef DMEM_MISALIGN_CHECK_EN
      req_err = is_misaligned(req_sz, req_addr[1:0]);
`else
      req_err = 1'b0;
`endif
   end

   // The RAM is driven from the live request when a zero-latency access
   // happens on the accept edge, and from the latched copy after a wait.
   // No access while reset is held, and never for an errored request.
   always_comb begin
      if (state == ST_IDLE) begin
         acc_we    = req_we;
         acc_size  = req_sz;
         acc_off   = req_off;
         acc_idx   = req_addr[ADDR_W+1:2];
         acc_wdata = req_wdata;
         acc_err   = req_err;
      end else begin
         acc_we    = lat_we;
         acc_size  = lat_size;
         acc_off   = lat_off;
         acc_idx   = lat_idx;
         acc_wdata = lat_wdata;
         acc_err   = lat_err;
      end
      acc_fire = 1'b0;
      if (rst_n && !acc_err) begin
         if (state == ST_IDLE && req_valid && LATENCY == 0) begin
            acc_fire = 1'b1;
         end else if (state == ST_WAIT && cnt == 4'd0) begin
            acc_fire = 1'b1;
         end
      end
      bank_we = (acc_fire && acc_we) ? gen_strobe(acc_size, acc_off) : 4'h0;
   end

   dmem_bank #(.ADDR_W(ADDR_W)) u_bank (
      .clk   (clk),
      .en    (acc_fire),
      .we    (bank_we),
      .addr  (acc_idx),
      .wdata (replicate(acc_size, acc_wdata)),
      .rdata (bank_rdata)
   );

   // State, wait counter and the captured request. Everything is captured on
   // the accept edge so the requester may change its inputs afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cnt        <= 4'd0;
         lat_we     <= 1'b0;
         lat_signed <= 1'b0;
         lat_err    <= 1'b0;
         lat_size   <= SZ_BYTE;
         lat_off    <= 2'b00;
         lat_idx    <= '0;
         lat_wdata  <= 32'h0;
      end else begin
         state <= state_n;
         if (state == ST_IDLE && req_valid) begin
            cnt        <= CNT_INIT;
            lat_we     <= req_we;
            lat_signed <= req_signed;
            lat_err    <= req_err;
            lat_size   <= req_sz;
            lat_off    <= req_off;
            lat_idx    <= req_addr[ADDR_W+1:2];
            lat_wdata  <= req_wdata;
         end else if (state == ST_WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
      end
   end

   // Next state and handshake outputs.
   always_comb begin
      state_n    = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_n = (LATENCY == 0) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt == 4'd0) begin
               state_n = ST_RESP;
            end
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               state_n = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Response payload is only meaningful in RESP; the bank read register is
   // untouched during RESP so the data stays stable under backpressure.
   always_comb begin
      resp_rdata = 32'h0;
      resp_err   = 1'b0;
      if (state == ST_RESP) begin
         resp_err = lat_err;
         if (!lat_we && !lat_err) begin
            resp_rdata = extract_load(bank_rdata, lat_size, lat_off, lat_signed);
         end
      end
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder that serves load/store requests issued by the pipeline's MEM stage over a valid/ready request channel and a valid/ready response channel. It holds a word-organised data RAM, applies byte/half/word write strobes, and returns lane-extracted, sign- or zero-extended load data after a programmable number of wait states. It is the slave end of the MEM-stage memory interface and replaces a direct block-RAM hookup when multi-cycle memory is modelled.

## Interface
- ADDR_W, 10, word-address bits; depth is 2^ADDR_W 32-bit words
- LATENCY, 1, wait cycles between accept and response (0..15)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset is asynchronous and active-low
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- req_signed  in  1  sign-extend load data (ignored for word and for stores)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  MEM stage consumes response
- resp_rdata  out  32  extended load data; 0 for stores and errored accesses
- resp_err  out  1  access was misaligned (only with check compiled in)

## Operation
- FSM states IDLE, WAIT, RESP; reset state IDLE.
- IDLE: req_ready=1. On req_valid: latch we/size/signed/addr/wdata; go WAIT if LATENCY>0 (counter loaded LATENCY-1), else perform access and go RESP.
- WAIT: req_ready=0; counter decrements each cycle; at 0 perform access, go RESP.
- Access: word index = addr[ADDR_W+1:2]; upper address bits ignored (aliasing wrap). Store: byte strobe from size/addr[1:0] (byte: 1<<a, half: 3<<a, word: 4'hF); wdata replicated into lanes (byte x4, half x2). Load: select lane by addr[1:0], extend per req_signed.
- RESP: resp_valid=1, rdata/err stable until resp_ready; on resp_valid&resp_ready go IDLE.
- Misaligned (half with addr[0]=1, word with addr[1:0]!=0): see Configuration.
- RAM contents not reset; undefined until written.

## Timing
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, state IDLE, counter 0.
- Accept edge = edge where req_valid&req_ready. resp_valid rises LATENCY+1 edges after accept.
- Store committed to RAM on the edge entering RESP; not earlier.
- Throughput: one transaction per LATENCY+2 cycles minimum (RESP handshake cycle plus IDLE accept cycle).
- resp_ready held high before resp_valid is legal; response consumed on first cycle of RESP.
- req_valid while not ready: ignored, no latching; requester holds the request.
- rst_n asserted mid-WAIT: transaction aborted, no store committed, outputs to reset values immediately.
- Read-after-write to same word in back-to-back transactions returns new data.

## Configuration
- DMEM_MISALIGN_CHECK_EN defined: misaligned access performs no RAM read/write, responds with resp_err=1, resp_rdata=0, same latency.
- Not defined: resp_err tied 0; misaligned address bits forced aligned (half ignores addr[0], word ignores addr[1:0]) and access proceeds.

## Structure
- Shared package dmem_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state typedef, strobe-generation and load-extract functions.
- Sub-module dmem_bank: 2^ADDR_W x 32 synchronous RAM with 4-bit byte write enable, one read/write port, registered read.

## Test plan
- Reset, LATENCY=1: store word 0xDEADBEEF @0x10, load word @0x10 -> resp_valid 2 cycles after each accept, rdata 0xDEADBEEF.
- Store byte 0xA5 @0x13 over 0x11223344, load byte signed @0x13 -> 0xFFFFFFA5; unsigned -> 0x000000A5; load word -> 0xA5223344.
- Store half 0x8001 @0x22, load half signed @0x22 -> 0xFFFF8001; unsigned -> 0x00008001.
- resp_ready low 5 cycles -> resp_valid/rdata stable, req_ready 0, second req_valid not accepted until after handshake.
- Load word @0x06 with check enabled -> resp_err=1, rdata 0, RAM unchanged; disabled -> reads word @0x04, err 0.
- rst_n low during WAIT of store 0x12345678 @0x40 -> subsequent load @0x40 returns prior contents; ADDR_W=10 load @0x1040 aliases @0x40.
